// File: rtl/hazard_pkg.sv
// Shared types for the producer-side hazard scoreboard: register addresses,
// the per-stage write record and helpers used by the stall and pending logic.
package hazard_pkg;

  localparam int AW            = 3;
  localparam int NREG          = 1 << AW;
  localparam int MC_LAT_DFLT   = 4;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [NREG-1:0] reg_mask_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      regwrite;
    logic      memread;
  } stage_entry_t;

  localparam stage_entry_t BUBBLE = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

  function automatic logic src_hit(input logic uses, input reg_addr_t src, input reg_addr_t rd);
    return uses && (src == rd);
  endfunction

  // One-hot of the register a stage will write, empty for non-writers.
  function automatic reg_mask_t write_mask(input stage_entry_t e);
    reg_mask_t m;
    m = '0;
    if (e.regwrite) m[e.rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_mc_busy_counter.sv
// Occupancy timer for a multicycle EX op: loaded on entry, counts down to zero,
// busy while nonzero. Flush and reset both clear it synchronously.
module mc_busy_counter
  import hazard_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic load,
  output logic mc_busy
);

  localparam int CW = $clog2(MC_LAT) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MC_LAT - 1);

  logic [CW-1:0] cnt;

  // MC_LAT=1 loads zero, so the op never holds EX and acts like an ALU op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end
  end

  assign mc_busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination/write-enable/load info through EX, MEM and WB, and raises
// stall for load-use hazards and while a multicycle op occupies EX.
module hazard_scoreboard #(
  parameter int AW     = 3,
  parameter int MC_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rs,
  input  logic [AW-1:0]        id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 id_multicycle,
  input  logic                 flush,
  output logic                 stall,
  output logic [AW-1:0]        ex_rd,
  output logic [AW-1:0]        mem_rd,
  output logic [AW-1:0]        wb_rd,
  output logic                 ex_regwrite,
  output logic                 mem_regwrite,
  output logic                 wb_regwrite,
  output logic                 mc_busy,
  output logic [(1<<AW)-1:0]   pending
);

  // Stage records are sized by the package; AW must stay equal to hazard_pkg::AW.
  import hazard_pkg::*;

  stage_entry_t ex_q, mem_q, wb_q;
  stage_entry_t id_entry, ex_d, mem_d;
  logic         load_use;
  logic         mc_load;

  always_comb begin
    id_entry = BUBBLE;
    if (id_valid) begin
      id_entry.rd       = id_rd;
      id_entry.regwrite = id_regwrite;
      id_entry.memread  = id_memread;
    end
  end

  always_comb begin
    load_use = ex_q.memread && ex_q.regwrite &&
               (src_hit(id_uses_rs, id_rs, ex_q.rd) || src_hit(id_uses_rt, id_rt, ex_q.rd));
    stall    = !flush && id_valid && (mc_busy || load_use);
  end

  always_comb begin
    ex_d = BUBBLE;
    if (flush) begin
      ex_d = BUBBLE;
    end else if (mc_busy) begin
      ex_d = ex_q;
    end else if (stall) begin
      ex_d = BUBBLE;
    end else begin
      ex_d = id_entry;
    end
  end

  // While EX is held the multicycle op must not also appear in MEM.
  always_comb begin
    mem_d = mc_busy ? BUBBLE : ex_q;
  end

  assign mc_load = !flush && !mc_busy && !stall && id_valid && id_multicycle && !id_memread;

  mc_busy_counter #(
    .MC_LAT (MC_LAT)
  ) u_mc_busy_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .load    (mc_load),
    .mc_busy (mc_busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
    end
  end

  always_comb begin
    ex_rd        = ex_q.rd;
    mem_rd       = mem_q.rd;
    wb_rd        = wb_q.rd;
    ex_regwrite  = ex_q.regwrite;
    mem_regwrite = mem_q.regwrite;
    wb_regwrite  = wb_q.regwrite;
    pending      = write_mask(ex_q) | write_mask(mem_q) | write_mask(wb_q);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: each scenario pushes timed expectations to a queue, and a
// negedge monitor pops and compares those due in the current cycle.
module tb_hazard_scoreboard;

  localparam int AW = 3;

  localparam int S_STALL  = 0;
  localparam int S_BUSY   = 1;
  localparam int S_EXRD   = 2;
  localparam int S_EXRW   = 3;
  localparam int S_MEMRD  = 4;
  localparam int S_MEMRW  = 5;
  localparam int S_WBRD   = 6;
  localparam int S_WBRW   = 7;
  localparam int S_PEND   = 8;
  localparam int S_ALL    = 9;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_uses_rs, id_uses_rt;
  logic          id_regwrite, id_memread, id_multicycle;
  logic          flush;
  logic          stall;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic          ex_regwrite, mem_regwrite, wb_regwrite;
  logic          mc_busy;
  logic [7:0]    pending;

  typedef struct {
    int          cyc;
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   c;

  hazard_scoreboard #(.AW(AW), .MC_LAT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_rd         (id_rd),
    .id_regwrite   (id_regwrite),
    .id_memread    (id_memread),
    .id_multicycle (id_multicycle),
    .flush         (flush),
    .stall         (stall),
    .ex_rd         (ex_rd),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .ex_regwrite   (ex_regwrite),
    .mem_regwrite  (mem_regwrite),
    .wb_regwrite   (wb_regwrite),
    .mc_busy       (mc_busy),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_STALL: return {31'b0, stall};
      S_BUSY:  return {31'b0, mc_busy};
      S_EXRD:  return {29'b0, ex_rd};
      S_EXRW:  return {31'b0, ex_regwrite};
      S_MEMRD: return {29'b0, mem_rd};
      S_MEMRW: return {31'b0, mem_regwrite};
      S_WBRD:  return {29'b0, wb_rd};
      S_WBRW:  return {31'b0, wb_regwrite};
      S_PEND:  return {24'b0, pending};
      default: return {10'b0, stall, mc_busy, ex_regwrite, mem_regwrite, wb_regwrite,
                       ex_rd, mem_rd, wb_rd, pending};
    endcase
  endfunction

  task automatic exp_at(input int at, input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.cyc = at;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        chk(q[i].tag, sample(q[i].sel), q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs, input logic urs,
                       input logic [AW-1:0] rt, input logic urt, input logic [AW-1:0] rd,
                       input logic rw, input logic mr, input logic mc, input logic fl);
    id_valid      = v;
    id_rs         = rs;
    id_uses_rs    = urs;
    id_rt         = rt;
    id_uses_rt    = urt;
    id_rd         = rd;
    id_regwrite   = rw;
    id_memread    = mr;
    id_multicycle = mc;
    flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) exp_at(cyc + k, "reset_idle_all", S_ALL, 32'h0);
    repeat (5) step();

    // ALU op rd=3
    c = cyc;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_at(c,     "alu_stall", S_STALL, 0);
    exp_at(c + 1, "alu_ex_rd", S_EXRD, 3);
    exp_at(c + 1, "alu_ex_rw", S_EXRW, 1);
    exp_at(c + 2, "alu_mem_rd", S_MEMRD, 3);
    exp_at(c + 2, "alu_mem_rw", S_MEMRW, 1);
    exp_at(c + 3, "alu_wb_rd", S_WBRD, 3);
    exp_at(c + 3, "alu_wb_rw", S_WBRW, 1);
    for (int k = 1; k <= 3; k++) begin
      exp_at(c + k, "alu_pending", S_PEND, 32'h08);
      exp_at(c + k, "alu_stall_after", S_STALL, 0);
    end
    exp_at(c + 4, "alu_pending_clear", S_PEND, 32'h00);
    step();
    drain(5);

    // load rd=5 then consumer reading rs=5
    c = cyc;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_at(c,     "lu_stall_load", S_STALL, 0);
    exp_at(c + 1, "lu_stall", S_STALL, 1);
    exp_at(c + 1, "lu_ex_rd_load", S_EXRD, 5);
    exp_at(c + 2, "lu_stall_one_cycle", S_STALL, 0);
    exp_at(c + 2, "lu_ex_bubble_rw", S_EXRW, 0);
    exp_at(c + 2, "lu_ex_bubble_rd", S_EXRD, 0);
    exp_at(c + 2, "lu_mem_rd_load", S_MEMRD, 5);
    exp_at(c + 3, "lu_ex_rd_consumer", S_EXRD, 6);
    exp_at(c + 3, "lu_ex_rw_consumer", S_EXRW, 1);
    step();
    drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    drain(5);

    // same sequence, source not read
    c = cyc;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_at(c + 1, "nouse_stall", S_STALL, 0);
    exp_at(c + 2, "nouse_ex_rd", S_EXRD, 6);
    step();
    drive(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drain(5);

    // load rd=5, consumer reads it through rt
    c = cyc;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_at(c + 1, "rt_stall", S_STALL, 1);
    exp_at(c + 2, "rt_stall_release", S_STALL, 0);
    exp_at(c + 3, "rt_ex_rd", S_EXRD, 6);
    step();
    drive(1'b1, 3'd0, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    drain(5);

    // multicycle rd=2 then independent op rd=4
    c = cyc;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_at(c, "mc_stall_issue", S_STALL, 0);
    for (int k = 1; k <= 3; k++) begin
      exp_at(c + k, "mc_busy", S_BUSY, 1);
      exp_at(c + k, "mc_stall", S_STALL, 1);
      exp_at(c + k, "mc_ex_rd_held", S_EXRD, 2);
      exp_at(c + k + 1, "mc_mem_bubble", S_MEMRW, 0);
    end
    exp_at(c + 2, "mc_pending", S_PEND, 32'h04);
    exp_at(c + 4, "mc_busy_end", S_BUSY, 0);
    exp_at(c + 4, "mc_stall_end", S_STALL, 0);
    exp_at(c + 4, "mc_ex_rd_last", S_EXRD, 2);
    exp_at(c + 5, "mc_ex_rd_next", S_EXRD, 4);
    exp_at(c + 5, "mc_mem_rd", S_MEMRD, 2);
    exp_at(c + 5, "mc_mem_rw", S_MEMRW, 1);
    exp_at(c + 6, "mc_wb_rd", S_WBRD, 2);
    exp_at(c + 6, "mc_mem_rd_next", S_MEMRD, 4);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    drain(6);

    // flush in the second EX cycle of a multicycle op
    c = cyc;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_at(c + 2, "fl_busy_before", S_BUSY, 1);
    exp_at(c + 2, "fl_mem_rd_older", S_MEMRD, 7);
    exp_at(c + 3, "fl_stall_in_flush", S_STALL, 0);
    exp_at(c + 3, "fl_wb_rd_older", S_WBRD, 7);
    exp_at(c + 3, "fl_mem_rw_bubble", S_MEMRW, 0);
    exp_at(c + 4, "fl_ex_rw", S_EXRW, 0);
    exp_at(c + 4, "fl_busy_after", S_BUSY, 0);
    exp_at(c + 4, "fl_mem_rw_after", S_MEMRW, 0);
    exp_at(c + 4, "fl_wb_rw_after", S_WBRW, 0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b1;
    step();
    drain(5);

    // load rd=1 in EX while ID reads r1 and flush is high
    c = cyc;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_at(c + 1, "flu_stall", S_STALL, 0);
    exp_at(c + 2, "flu_ex_rw", S_EXRW, 0);
    exp_at(c + 2, "flu_ex_rd", S_EXRD, 0);
    exp_at(c + 2, "flu_mem_rd", S_MEMRD, 1);
    exp_at(c + 2, "flu_mem_rw", S_MEMRW, 1);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drain(6);

    chk("leftover_expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
